// File: rtl/ysyx_220053_div_pkg.sv
// Shared definitions for the iterative integer divider.
// Contents: counter width, op encodings (DIV/DIVU/REM/REMU), FSM state
// encoding and small op-decode helpers.
package ysyx_220053_div_pkg;

    localparam int unsigned CNT_W = 7;
    localparam int unsigned OP_W  = 2;

    typedef enum logic [OP_W-1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    // Bit 0 of the op selects unsigned, bit 1 selects remainder.
    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [OP_W-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ysyx_220053_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_sh      - partial remainder shifted left with the next dividend bit
//                 appended (one bit wider than XLEN)
//   divisor     - divisor magnitude
//   rem_next_c  - partial remainder after the conditional subtract
//   q_bit_c     - quotient bit produced by this step
module ysyx_220053_div_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN:0]   rem_sh,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next_c,
    output logic            q_bit_c
);

    logic [XLEN-1:0] diff;

    // When the subtract succeeds the result is below the divisor, so the
    // low XLEN bits of the difference are exact.
    always_comb begin
        diff       = rem_sh[XLEN-1:0] - divisor;
        q_bit_c    = (rem_sh >= {1'b0, divisor});
        rem_next_c = q_bit_c ? diff : rem_sh[XLEN-1:0];
    end

endmodule

// File: rtl/ysyx_220053_div.sv
// Iterative RV64M divider (DIV/DIVU/REM/REMU and W-variants).
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - operation handshake (in_ready only in IDLE)
//   in_op, in_word        - op select and 32-bit W-variant select
//   in_a, in_b, in_rd     - dividend, divisor, destination tag
//   flush                 - abort any operation in flight
//   out_valid/out_ready   - result handshake
//   out_data, out_rd      - result and its destination tag
module ysyx_220053_div
    import ysyx_220053_div_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RD_W-1:0] out_rd
);

    div_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem_r, quo_r, dvs_r;
    logic            neg_q, neg_r, rem_sel, word_r;
    logic [RD_W-1:0] rd_r;

    logic            sgn, a_neg, b_neg, div_zero, ovf, special, accept;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic [XLEN-1:0] res_raw, res_sgn, res_fix;
    logic            res_neg;

    assign in_ready = (state == S_IDLE);

    // Operand conditioning: W-extension, magnitudes and special cases.
    always_comb begin
        sgn      = op_is_signed(in_op);
        a_ext    = in_a;
        b_ext    = in_b;
        if (in_word) begin
            a_ext = {{(XLEN-32){sgn & in_a[31]}}, in_a[31:0]};
            b_ext = {{(XLEN-32){sgn & in_b[31]}}, in_b[31:0]};
        end
        a_neg    = sgn & a_ext[XLEN-1];
        b_neg    = sgn & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        min_val  = in_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        ovf      = sgn & (b_ext == '1) & (a_ext == min_val);
        special  = div_zero | ovf;
        accept   = (state == S_IDLE) & in_valid & ~flush;
    end

    ysyx_220053_div_step #(.XLEN(XLEN)) u_step (
        .rem_sh     ({rem_r, quo_r[XLEN-1]}),
        .divisor    (dvs_r),
        .rem_next_c (step_rem),
        .q_bit_c    (step_q)
    );

    // Final sign correction and W-variant sign extension.
    always_comb begin
        res_raw = rem_sel ? rem_r : quo_r;
        res_neg = rem_sel ? neg_r : neg_q;
        res_sgn = res_neg ? -res_raw : res_raw;
        res_fix = word_r ? {{(XLEN-32){res_sgn[31]}}, res_sgn[31:0]} : res_sgn;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = special ? S_DONE : S_CALC;
            S_CALC:  if (cnt == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE:  if (out_valid && out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            rem_sel   <= 1'b0;
            word_r    <= 1'b0;
            rd_r      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rd    <= '0;
        end else begin
            if (accept) begin
                rem_sel <= op_is_rem(in_op);
                word_r  <= in_word;
                rd_r    <= in_rd;
                dvs_r   <= b_mag;
                // Special cases preload the final answer with no sign fix-up.
                if (div_zero) begin
                    cnt   <= '0;
                    quo_r <= '1;
                    rem_r <= a_ext;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else if (ovf) begin
                    cnt   <= '0;
                    quo_r <= a_ext;
                    rem_r <= '0;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else begin
                    cnt   <= CNT_W'(XLEN);
                    quo_r <= a_mag;
                    rem_r <= '0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                end
            end

            // quo_r shifts dividend bits out of the top and quotient bits in.
            if (state == S_CALC) begin
                rem_r <= step_rem;
                quo_r <= {quo_r[XLEN-2:0], step_q};
                cnt   <= cnt - CNT_W'(1);
            end

            if (flush) begin
                out_valid <= 1'b0;
            end else if (state == S_DONE && !out_valid) begin
                out_valid <= 1'b1;
                out_data  <= res_fix;
                out_rd    <= rd_r;
            end else if (state == S_DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_220053_div.sv
// Directed self-checking bench for ysyx_220053_div.
module tb_ysyx_220053_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_word;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;
    localparam logic [63:0] M2   = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] M3   = 64'hFFFF_FFFF_FFFF_FFFD;

    always #5 clk = ~clk;

    ysyx_220053_div #(.XLEN(64), .RD_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_word   (in_word),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rd     (in_rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Present one op in IDLE; returns just after the accepting edge.
    task automatic launch(input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_word  = w;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the result, check latency/data/tag, optionally stall, then hand off.
    task automatic finish_op(input string tag, input int exp_lat, input logic [63:0] exp_data,
                             input logic [4:0] exp_rd, input int stall);
        int lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_rd"}, 64'(out_rd), 64'(exp_rd));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_data"}, out_data, exp_data);
            check({tag, "_hold_rd"}, 64'(out_rd), 64'(exp_rd));
        end
        out_ready = 1'b1;
        check({tag, "_no_ready_in_done"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input int exp_lat, input logic [63:0] exp_data);
        launch(op, w, a, b, rd);
        finish_op(tag, exp_lat, exp_data, rd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0;
        in_a = '0; in_b = '0; in_rd = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        do_op("div_m7_2",     DIV,  1'b0, M7, 64'd2, 5'd1, 65, M3);
        do_op("rem_m7_2",     REM,  1'b0, M7, 64'd2, 5'd2, 65, ONES);
        do_op("divu_5_0",     DIVU, 1'b0, 64'd5, 64'd0, 5'd3, 1, ONES);
        do_op("remu_5_0",     REMU, 1'b0, 64'd5, 64'd0, 5'd4, 1, 64'd5);
        do_op("div_ovf",      DIV,  1'b0, 64'h8000_0000_0000_0000, ONES, 5'd5, 1,
              64'h8000_0000_0000_0000);
        do_op("divw_ovf",     DIV,  1'b1, 64'h0000_0000_8000_0000, ONES, 5'd6, 1,
              64'hFFFF_FFFF_8000_0000);
        do_op("remuw",        REMU, 1'b1, 64'h0000_0001_0000_0007, 64'd3, 5'd7, 65, 64'd1);
        do_op("divuw",        DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd8, 65, ONES);
        do_op("div_7_m2",     DIV,  1'b0, 64'd7, M2, 5'd10, 65, M3);
        do_op("rem_m7_m2",    REM,  1'b0, M7, M2, 5'd11, 65, ONES);
        do_op("divu_big",     DIVU, 1'b0, ONES, 64'd16, 5'd12, 65, 64'h0FFF_FFFF_FFFF_FFFF);
        do_op("divw_m7_2",    DIV,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd13, 65, M3);
        do_op("remw_m7_2",    REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd14, 65, ONES);

        // Consumer stalls for 10 cycles in DONE.
        launch(DIVU, 1'b0, 64'd100, 64'd7, 5'd9);
        finish_op("stall", 65, 64'd14, 5'd9, 10);

        // Flush deep in CALC with a new op pending: nothing emitted, no accept.
        launch(DIV, 1'b0, M7, 64'd2, 5'd20);
        repeat (29) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = DIVU; in_word = 1'b0;
        in_a = 64'd100; in_b = 64'd7; in_rd = 5'd21;
        @(posedge clk);
        #1;
        check("flush_no_valid", 64'(out_valid), 64'd0);
        check("flush_no_accept", 64'(in_ready), 64'd1);
        flush = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("flush_next_accepted", 64'(in_ready), 64'd0);
        finish_op("flush_next", 65, 64'd14, 5'd21, 0);

        // Reset in the middle of CALC discards the op.
        launch(REMU, 1'b0, 64'd100, 64'd7, 5'd22);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        check("mid_rst_rd", 64'(out_rd), 64'd0);
        do_op("after_rst", REMU, 1'b0, 64'd100, 64'd7, 5'd23, 65, 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
